// File: rtl/serial_adder_if.sv
// serial_adder_if: start/busy/done handshake, operand and result bus for serial_adder.
// Optional ovf signal present only when SERIAL_ADD_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned N = 8
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         c_out;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out, ovf
  );
`else
  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder built around one full-adder cell.
// Operands shift LSB first through the cell, carry is held in a flop between
// bits, and the N-bit sum is assembled in a right-shifting partial-sum register.
// Optional signed overflow flag enabled by defining SERIAL_ADD_OVF_EN.
module serial_adder #(
  parameter int unsigned N = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  opa_q, opa_d;
  logic [N-1:0]  opb_q, opb_d;
  logic [N-1:0]  psum_q, psum_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_bit;

  // Full-adder cell signals
  logic          fa_x, fa_y, fa_ci;
  logic          fa_s, fa_co;

`ifdef SERIAL_ADD_OVF_EN
  logic          ovf_q, ovf_d;
  logic          cmsb;
`endif

  // One-bit full-adder cell fed from the operand LSBs and the carry flop
  always_comb begin
    fa_x  = opa_q[0];
    fa_y  = opb_q[0];
    fa_ci = carry_q;
    fa_s  = fa_x ^ fa_y ^ fa_ci;
    fa_co = (fa_x & fa_y) | (fa_ci & (fa_x ^ fa_y));
  end

  assign last_bit = (cnt_q == CW'(N - 1));

`ifdef SERIAL_ADD_OVF_EN
  // Carry into the MSB is the carry flop while the last bit is in the cell
  assign cmsb = carry_q;
`endif

  // Next-state, datapath shift and result capture
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          opa_d   = bus.a;
          opb_d   = bus.b;
          carry_d = bus.c_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        psum_d  = {fa_s, psum_q[N-1:1]};
        carry_d = fa_co;
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        // Counter holds on the last bit so it never wraps for power-of-two N
        if (!last_bit) begin
          cnt_d = cnt_q + CW'(1);
        end
        if (last_bit) begin
          state_d = DONE;
          sum_d   = {fa_s, psum_q[N-1:1]};
          cout_d  = fa_co;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = cmsb ^ fa_co;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      psum_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      psum_q  <= psum_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  // Overflow flag register, written together with sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`endif

  // Output drive: handshake decoded from state, results from holding registers
  always_comb begin
    bus.busy  = (state_q == SHIFT);
    bus.done  = (state_q == DONE);
    bus.sum   = sum_q;
    bus.c_out = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    bus.ovf   = ovf_q;
`endif
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of serial_adder at N=8 (with a per-cycle
// edge-count model) and an exhaustive sweep at N=2.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_adder_if #(.N(8)) if8 ();
  serial_adder_if #(.N(2)) if2 ();

  serial_adder #(.N(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.N(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- N=8 model: edge numbers and plain arithmetic -------------
  int       ecnt      = 0;
  bit       m_act     = 1'b0;
  int       m_acc     = 0;
  bit [8:0] m_res     = '0;
  bit       m_ovf_n   = 1'b0;
  int       m_done_at = -100;
  bit [7:0] m_sum     = '0;
  bit       m_cout    = 1'b0;
  bit       m_ovf     = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt      <= 0;
      m_act     <= 1'b0;
      m_done_at <= -100;
      m_sum     <= '0;
      m_cout    <= 1'b0;
      m_ovf     <= 1'b0;
    end else begin
      ecnt <= ecnt + 1;
      if (m_act && (ecnt + 1 == m_acc + 8)) begin
        m_act     <= 1'b0;
        m_done_at <= ecnt + 1;
        m_sum     <= m_res[7:0];
        m_cout    <= m_res[8];
        m_ovf     <= m_ovf_n;
      end
      if (!m_act && if8.start) begin
        m_act   <= 1'b1;
        m_acc   <= ecnt + 1;
        m_res   <= 9'(if8.a) + 9'(if8.b) + 9'(if8.c_in);
        m_ovf_n <= (if8.a[7] == if8.b[7]) &&
                   (((9'(if8.a) + 9'(if8.b) + 9'(if8.c_in)) >> 7) % 2 != 9'(if8.a[7]));
      end
    end
  end

  bit chk_en = 1'b0;

  // Per-cycle comparison of the N=8 DUT against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy",  if8.busy,  m_act);
      chk("done",  if8.done,  ecnt == m_done_at);
      chk("sum",   if8.sum,   m_sum);
      chk("c_out", if8.c_out, m_cout);
`ifdef SERIAL_ADD_OVF_EN
      chk("ovf",   if8.ovf,   m_ovf);
`endif
    end
  end

  int dcnt8 = 0;
  always @(posedge clk) if (if8.done === 1'b1) dcnt8++;

  // ---------------- stimulus helpers ----------------
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
    @(negedge clk);
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.c_in = c;
    @(negedge clk);
    if8.start = 1'b0; if8.a = 8'hEE; if8.b = 8'h77; if8.c_in = 1'b1;
  endtask

  // lat0 = edges already elapsed counting the accepting edge as 1
  task automatic wait_done8(input int lat0, output int lat);
    lat = lat0;
    while (if8.done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [7:0] es, input logic ec, input logic eo);
    int lat;
    issue8(a, b, c);
    wait_done8(1, lat);
    chk({nm, "_lat"},  lat, 9);
    chk({nm, "_sum"},  if8.sum, es);
    chk({nm, "_cout"}, if8.c_out, ec);
`ifdef SERIAL_ADD_OVF_EN
    chk({nm, "_ovf"},  if8.ovf, eo);
`else
    if (eo) begin end
`endif
    @(negedge clk);
    chk({nm, "_pulse"}, if8.done, 1'b0);
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic c);
    int lat;
    logic [2:0] exp;
    @(negedge clk);
    if2.start = 1'b1; if2.a = a; if2.b = b; if2.c_in = c;
    @(negedge clk);
    if2.start = 1'b0; if2.a = ~a; if2.b = ~b; if2.c_in = ~c;
    lat = 1;
    while (if2.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    exp = 3'(a) + 3'(b) + 3'(c);
    chk("n2_lat", lat, 3);
    chk("n2_res", {if2.c_out, if2.sum}, exp);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int d0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.c_in = 1'b0;
    if2.start = 1'b0; if2.a = '0; if2.b = '0; if2.c_in = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", if8.busy, 1'b0);
    chk("rst_done", if8.done, 1'b0);
    chk("rst_sum",  if8.sum, 8'h00);
    chk("rst_cout", if8.c_out, 1'b0);
    rst_n = 1'b1;

    op8("basic",  8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b0);
    op8("carry1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("carry2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Start pulse mid-SHIFT must be ignored
    d0 = dcnt8;
    issue8(8'h10, 8'h20, 1'b0);
    repeat (3) @(negedge clk);
    if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01; if8.c_in = 1'b0;
    @(negedge clk);
    if8.start = 1'b0;
    wait_done8(5, lat);
    chk("ign_lat", lat, 9);
    chk("ign_sum", if8.sum, 8'h30);
    // Back-to-back: start during the DONE cycle
    if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h02; if8.c_in = 1'b0;
    @(negedge clk);
    if8.start = 1'b0;
    chk("b2b_nogap", if8.busy, 1'b1);
    wait_done8(1, lat);
    chk("b2b_lat", lat, 9);
    chk("b2b_sum", if8.sum, 8'h03);
    chk("ign_one_done", dcnt8 - d0, 1);
    repeat (12) @(negedge clk);
    chk("ign_no_extra", dcnt8 - d0, 2);

    // Reset mid-operation
    issue8(8'hAA, 8'h55, 1'b0);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mrst_busy", if8.busy, 1'b0);
    chk("mrst_done", if8.done, 1'b0);
    chk("mrst_sum",  if8.sum, 8'h00);
    chk("mrst_cout", if8.c_out, 1'b0);
`ifdef SERIAL_ADD_OVF_EN
    chk("mrst_ovf",  if8.ovf, 1'b0);
`endif
    d0 = dcnt8;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mrst_nodone", dcnt8 - d0, 0);
    op8("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

`ifdef SERIAL_ADD_OVF_EN
    op8("ovf_pos", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op8("ovf_neg", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    op8("ovf_no",  8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
`endif

    // Exhaustive N=2 sweep
    for (int ia = 0; ia < 4; ia++) begin
      for (int ib = 0; ib < 4; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          op2(2'(ia), 2'(ib), 1'(ic));
        end
      end
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around a single full-adder cell: the operands are shifted through it one bit per clock, LSB first, and the carry is kept in a flip-flop between bits. It sits directly upstream of the one-bit full adder and feeds it each cycle's x, y and c_in. It also consumes that cell's s and c_out to assemble an N-bit sum with a start/busy/done handshake. It is the area-minimal alternative to an N-cell ripple adder.

## Interface
- N, default 8 — operand and sum width; legal range N ≥ 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled on rising clk; accepted only when the block is idle.
- a  input  N  operand A; captured when start is accepted.
- b  input  N  operand B; captured when start is accepted.
- c_in  input  1  initial carry; captured when start is accepted.
- busy  output  1  high while a serial add is in progress.
- done  output  1  one-cycle pulse when sum and c_out become valid.
- sum  output  N  result register; holds its value until the next result is written.
- c_out  output  1  final carry; holds its value until the next result is written.
- ovf  output  1  signed overflow flag; present only when SERIAL_ADD_OVF_EN is defined.

## Operation
- The FSM has three states: IDLE, SHIFT and DONE.
- **Reset:** while rst_n = 0 the state is IDLE. All of the following are 0: busy, done, sum, c_out, ovf, the shift registers, the carry flop and the bit counter.
- **Accepting start:** in IDLE or DONE, start = 1 at a rising edge does all of the following:
  - loads a and b into the operand shift registers;
  - loads c_in into the carry flop;
  - clears the counter;
  - moves the FSM to SHIFT.
- **SHIFT, each cycle:** the full-adder cell receives x = opA[0], y = opB[0], c_in = carry. At the next edge:
  - the cell's s is shifted into the MSB of the partial-sum register, which shifts right;
  - carry ← cell c_out;
  - both operand registers shift right;
  - the counter increments.
- **Leaving SHIFT:** on the edge that completes bit N-1, the FSM moves to DONE. On that same edge, sum ← the completed partial sum and c_out ← the final carry.
- **DONE:** lasts exactly one cycle with done = 1. The FSM then returns to IDLE, unless start is asserted in that cycle, which begins a new add.
- **start while in SHIFT** is ignored; no queueing.
- **Arithmetic:** {c_out, sum} = a + b + c_in, unsigned, modulo 2^(N+1). This is exact.
- **Partial results:** sum and c_out never show intermediate values during SHIFT.
- **Counter:** wide enough to count to N-1. It never wraps inside an operation.

## Timing
- Call the edge that accepts start edge 0.
- busy = 1 from after edge 0 through after edge N-1. busy = 0 after edge N.
- done = 1 and the result is valid in the cycle after edge N.
- Latency from start acceptance to done is N+1 edges.
- Throughput is one add per N+1 cycles; back-to-back operation is allowed by asserting start during the DONE cycle.
- a, b and c_in may change freely after edge 0.
- rst_n falling at any point, including mid-SHIFT or during DONE, immediately forces the reset values above. The operation is abandoned, and done does not pulse for it.
- After rst_n rises, the first start is honoured on the first rising edge at which it is sampled.

## Configuration
- **SERIAL_ADD_OVF_EN defined:**
  - adds output ovf;
  - the carry into bit N-1 is captured during the final SHIFT cycle;
  - at the edge where sum is written, ovf ← (carry into MSB) XOR (carry out of MSB);
  - ovf holds with sum and resets to 0.
- **SERIAL_ADD_OVF_EN undefined:** the ovf port and its logic are absent; all other behaviour is identical.

## Test plan
- **Basic add:** reset, then N=8 with a=0x5A, b=0x3C, c_in=0, start for 1 cycle. Expect busy high for 8 cycles, done pulse 9 edges after acceptance, sum=0x96, c_out=0.
- **Carry out:** a=0xFF, b=0x01, c_in=0 → sum=0x00, c_out=1. Then a=0xFF, b=0xFF, c_in=1 → sum=0xFF, c_out=1.
- **Ignored and back-to-back starts:**
  - start a=0x10, b=0x20; pulse start again mid-SHIFT with a=0x01, b=0x01 → only one done, sum=0x30.
  - Then assert start in the DONE cycle with a=0x01, b=0x02 → next done exactly 9 edges later, sum=0x03, and no idle gap.
- **Reset mid-operation:** start a=0xAA, b=0x55; drop rst_n after 4 cycles → all outputs 0 immediately and no done pulse. After release, start a=0x01, b=0x01 → sum=0x02.
- **Overflow (SERIAL_ADD_OVF_EN defined):**
  - a=0x7F, b=0x01 → sum=0x80, c_out=0, ovf=1.
  - a=0x80, b=0x80 → sum=0x00, c_out=1, ovf=1.
  - a=0x05, b=0x03 → ovf=0.
- **Exhaustive, N=2 parameterisation:** all 32 combinations of a, b and c_in compared against a+b+c_in, with done latency checked = 3 edges each.
